// File: rtl/rvfi_bus_pkg.sv
// Shared types and widths for the RVFI bus fault responder and its checkers.
package rvfi_bus_pkg;

    localparam int XLEN      = 32;
    localparam int BUSLEN    = 32;
    localparam int BUS_BYTES = BUSLEN / 8;
    localparam int WIN_BYTES = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic                 instr;
        logic [XLEN-1:0]      addr;
        logic [BUS_BYTES-1:0] rmask;
        logic [BUS_BYTES-1:0] wmask;
        logic [BUSLEN-1:0]    wdata;
    } req_t;

    function automatic logic [BUSLEN-1:0] lane_bits(input logic [BUS_BYTES-1:0] mask);
        logic [BUSLEN-1:0] bits;
        bits = '0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            bits[i*8 +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/rvfi_bus_fault_responder_if.sv
// Native memory port plus single-channel RVFI bus trace stream.
interface rvfi_bus_fault_responder_if;
    import rvfi_bus_pkg::*;

    logic                 mem_valid;
    logic                 mem_instr;
    logic [XLEN-1:0]      mem_addr;
    logic [BUS_BYTES-1:0] mem_rmask;
    logic [BUS_BYTES-1:0] mem_wmask;
    logic [BUSLEN-1:0]    mem_wdata;
    logic                 mem_ready;
    logic [BUSLEN-1:0]    mem_rdata;
    logic                 mem_fault;

    logic                 rvfi_bus_valid;
    logic                 rvfi_bus_insn;
    logic                 rvfi_bus_data;
    logic                 rvfi_bus_fault;
    logic [XLEN-1:0]      rvfi_bus_addr;
    logic [BUS_BYTES-1:0] rvfi_bus_rmask;
    logic [BUS_BYTES-1:0] rvfi_bus_wmask;
    logic [BUSLEN-1:0]    rvfi_bus_rdata;
    logic [BUSLEN-1:0]    rvfi_bus_wdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_rmask, mem_wmask, mem_wdata,
        input  mem_ready, mem_rdata, mem_fault,
        input  rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault,
        input  rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata, rvfi_bus_wdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_rmask, mem_wmask, mem_wdata,
        output mem_ready, mem_rdata, mem_fault,
        output rvfi_bus_valid, rvfi_bus_insn, rvfi_bus_data, rvfi_bus_fault,
        output rvfi_bus_addr, rvfi_bus_rmask, rvfi_bus_wmask, rvfi_bus_rdata, rvfi_bus_wdata
    );

endinterface

// File: rtl/rvfi_bus_window_hit.sv
// Combinational overlap test between the enabled bus lanes and the fault window.
module rvfi_bus_window_hit
    import rvfi_bus_pkg::*;
(
    input  logic [XLEN-1:0]      addr,
    input  logic [BUS_BYTES-1:0] lane_en,
    input  logic [XLEN-1:0]      fault_addr,
    output logic                 hit
);

    // Byte-by-byte equality in modulo-2^XLEN arithmetic, so the window wraps through 0.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < BUS_BYTES; i++) begin
            for (int j = 0; j < WIN_BYTES; j++) begin
                if (lane_en[i] && ((addr + XLEN'(i)) == (fault_addr + XLEN'(j)))) begin
                    hit = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rvfi_bus_fault_responder.sv
// Memory responder with programmable latency, fault window injection and RVFI bus trace.
// Define RISCV_FORMAL_BUS_FAULT_INSN_EN to let the fault window also hit instruction fetches.
module rvfi_bus_fault_responder
    import rvfi_bus_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    rvfi_bus_fault_responder_if.slave   bus,
    input  logic [XLEN-1:0]             fault_addr,
    input  logic [BUSLEN-1:0]           src_rdata,
    input  logic                        stall
);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    req_t              req;
    logic              hit;
    logic              fault;
    logic [BUSLEN-1:0] rdata;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            req <= '0;
        end else begin
            case (state)
                IDLE: if (bus.mem_valid) begin
                    req <= '{instr: bus.mem_instr, addr: bus.mem_addr, rmask: bus.mem_rmask,
                             wmask: bus.mem_wmask, wdata: bus.mem_wdata};
                    cnt <= 4'(LATENCY - 1);
                end
                WAIT: if (!stall && cnt != 4'd0) cnt <= cnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.mem_valid) state_nxt = WAIT;
            WAIT:    if (!stall && cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    rvfi_bus_window_hit u_window_hit (
        .addr       (req.addr),
        .lane_en    (req.rmask | req.wmask),
        .fault_addr (fault_addr),
        .hit        (hit)
    );

`ifdef RISCV_FORMAL_BUS_FAULT_INSN_EN
    assign fault = hit;
`else
    assign fault = hit & ~req.instr;
`endif

    assign rdata = fault ? '0 : (src_rdata & lane_bits(req.rmask));

    always_comb begin
        bus.mem_ready      = 1'b0;
        bus.mem_rdata      = '0;
        bus.mem_fault      = 1'b0;
        bus.rvfi_bus_valid = 1'b0;
        bus.rvfi_bus_insn  = 1'b0;
        bus.rvfi_bus_data  = 1'b0;
        bus.rvfi_bus_fault = 1'b0;
        bus.rvfi_bus_addr  = '0;
        bus.rvfi_bus_rmask = '0;
        bus.rvfi_bus_wmask = '0;
        bus.rvfi_bus_rdata = '0;
        bus.rvfi_bus_wdata = '0;
        if (state == RESP) begin
            bus.mem_ready      = 1'b1;
            bus.mem_rdata      = rdata;
            bus.mem_fault      = fault;
            bus.rvfi_bus_valid = 1'b1;
            bus.rvfi_bus_insn  = req.instr;
            bus.rvfi_bus_data  = ~req.instr;
            bus.rvfi_bus_fault = fault;
            bus.rvfi_bus_addr  = req.addr;
            bus.rvfi_bus_rmask = req.rmask;
            bus.rvfi_bus_wmask = req.wmask;
            bus.rvfi_bus_rdata = rdata;
            bus.rvfi_bus_wdata = req.wdata;
        end
    end

endmodule

// File: tb/tb_rvfi_bus_fault_responder.sv
// Randomized and directed bench for rvfi_bus_fault_responder against a behavioural model.
module tb_rvfi_bus_fault_responder;
    import rvfi_bus_pkg::*;

    localparam int LAT = 2;
`ifdef RISCV_FORMAL_BUS_FAULT_INSN_EN
    localparam bit INSN_FAULT = 1'b1;
`else
    localparam bit INSN_FAULT = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [31:0] fault_addr = '0;
    logic [31:0] src_rdata  = '0;
    int          n_checks = 0;
    int          n_errors = 0;

    rvfi_bus_fault_responder_if bus ();

    rvfi_bus_fault_responder #(.LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .fault_addr (fault_addr),
        .src_rdata  (src_rdata),
        .stall      (stall)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Distance of each enabled byte from the window base, modulo 2^32.
    function automatic bit model_fault(input bit instr, input logic [31:0] addr,
                                       input logic [3:0] lanes, input logic [31:0] fa);
        logic [31:0] d;
        if (instr && !INSN_FAULT) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = addr + 32'(i) - fa;
            if (lanes[i] && d < 32'd4) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_rdata(input bit f, input logic [31:0] src,
                                                input logic [3:0] rm);
        logic [31:0] r;
        r = '0;
        if (!f) begin
            for (int i = 0; i < 4; i++) if (rm[i]) r[i*8 +: 8] = src[i*8 +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] any_output();
        return {63'd0, bus.mem_ready | bus.mem_fault | (|bus.mem_rdata) | bus.rvfi_bus_valid |
                bus.rvfi_bus_insn | bus.rvfi_bus_data | bus.rvfi_bus_fault | (|bus.rvfi_bus_addr) |
                (|bus.rvfi_bus_rmask) | (|bus.rvfi_bus_wmask) | (|bus.rvfi_bus_rdata) |
                (|bus.rvfi_bus_wdata)};
    endfunction

    task automatic do_reset(input logic [31:0] fa);
        @(negedge clock);
        reset = 1'b1;
        stall = 1'b0;
        bus.mem_valid = 1'b0;
        fault_addr = fa;
        @(negedge clock);
        reset = 1'b0;
        check("reset_outputs_zero", any_output(), 64'd0);
    endtask

    task automatic xfer(input bit instr, input logic [31:0] addr, input logic [3:0] rm,
                        input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] src,
                        input int stall_len, input bit drop_valid);
        int  k;
        bit  seen;
        bit  early;
        bit  f;
        logic [31:0] erd;
        f   = model_fault(instr, addr, rm | wm, fault_addr);
        erd = model_rdata(f, src, rm);
        @(negedge clock);
        bus.mem_valid = 1'b1;
        bus.mem_instr = instr;
        bus.mem_addr  = addr;
        bus.mem_rmask = rm;
        bus.mem_wmask = wm;
        bus.mem_wdata = wd;
        src_rdata     = src;
        @(posedge clock);
        #1;
        bus.mem_instr = ~instr;
        bus.mem_addr  = $urandom;
        bus.mem_rmask = 4'($urandom);
        bus.mem_wmask = 4'($urandom);
        bus.mem_wdata = $urandom;
        if (stall_len > 0) stall = 1'b1;
        if (drop_valid) bus.mem_valid = 1'b0;
        seen  = 1'b0;
        early = 1'b0;
        k     = 0;
        while (!seen && k < LAT + stall_len + 20) begin
            @(negedge clock);
            k++;
            if (k == stall_len + 1) stall = 1'b0;
            if (bus.mem_ready) seen = 1'b1;
            else if (any_output() != 64'd0) early = 1'b1;
        end
        stall = 1'b0;
        check("no_early_outputs", 64'(early), 64'd0);
        check("ready_seen", 64'(seen), 64'd1);
        check("latency", 64'(k), 64'(LAT + 1 + stall_len));
        check("mem_fault", 64'(bus.mem_fault), 64'(f));
        check("mem_rdata", 64'(bus.mem_rdata), 64'(erd));
        check("rvfi_valid", 64'(bus.rvfi_bus_valid), 64'd1);
        check("rvfi_insn_data", {62'd0, bus.rvfi_bus_insn, bus.rvfi_bus_data}, {62'd0, instr, ~instr});
        check("rvfi_fault", 64'(bus.rvfi_bus_fault), 64'(f));
        check("rvfi_addr", 64'(bus.rvfi_bus_addr), 64'(addr));
        check("rvfi_masks", {56'd0, bus.rvfi_bus_rmask, bus.rvfi_bus_wmask}, {56'd0, rm, wm});
        check("rvfi_rdata", 64'(bus.rvfi_bus_rdata), 64'(erd));
        check("rvfi_wdata", 64'(bus.rvfi_bus_wdata), 64'(wd));
        bus.mem_valid = 1'b0;
        @(negedge clock);
        check("one_cycle_strobe", any_output(), 64'd0);
    endtask

    task automatic reset_in_wait();
        bit leaked;
        @(negedge clock);
        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h100;
        bus.mem_rmask = 4'hF;
        bus.mem_wmask = 4'h0;
        src_rdata     = 32'h1234_5678;
        @(negedge clock);
        reset = 1'b1;
        bus.mem_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check("reset_in_wait_outputs_zero", any_output(), 64'd0);
        leaked = 1'b0;
        repeat (LAT + 6) begin
            @(negedge clock);
            if (bus.mem_ready || bus.rvfi_bus_valid) leaked = 1'b1;
        end
        check("reset_in_wait_dropped", 64'(leaked), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fa, a;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_rmask = '0;
        bus.mem_wmask = '0;
        bus.mem_wdata = '0;

        do_reset(32'h200);
        xfer(1'b0, 32'h100, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);

        do_reset(32'h1FF);
        xfer(1'b0, 32'h1FC, 4'h0, 4'h8, 32'hA5A5_0001, 32'h5555_AAAA, 0, 1'b0);
        xfer(1'b0, 32'h1FC, 4'h0, 4'h7, 32'hA5A5_0002, 32'h5555_AAAA, 0, 1'b0);

        do_reset(32'h200);
        xfer(1'b1, 32'h200, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        xfer(1'b0, 32'h200, 4'hF, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        xfer(1'b0, 32'h200, 4'h0, 4'h0, 32'h0, 32'hCAFE_F00D, 0, 1'b0);

        do_reset(32'hFFFF_FFFE);
        xfer(1'b0, 32'h0, 4'h1, 4'h0, 32'h0, 32'h0BAD_CAFE, 0, 1'b0);
        xfer(1'b0, 32'h0, 4'h4, 4'h0, 32'h0, 32'h0BAD_CAFE, 0, 1'b0);

        do_reset(32'h200);
        xfer(1'b0, 32'h100, 4'hF, 4'h0, 32'h0, 32'h1357_9BDF, 5, 1'b1);

        reset_in_wait();
        xfer(1'b0, 32'h104, 4'h3, 4'h0, 32'h0, 32'h2468_ACE0, 0, 1'b0);

        for (int g = 0; g < 5; g++) begin
            fa = $urandom;
            do_reset(fa);
            for (int t = 0; t < 10; t++) begin
                a = (fa + 32'($urandom_range(0, 16)) - 32'd8) & 32'hFFFF_FFFC;
                xfer(1'($urandom_range(0, 1)), a, 4'($urandom), 4'($urandom), $urandom, $urandom,
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                     1'($urandom_range(0, 1)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
